md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler for the P7 pipeline, with its HI/LO register pair.
- Accepts one operation from the E stage and latches the operands.
- Holds busy for a fixed latency, then commits results to HI/LO.
- Generates the stall request the hazard unit uses for D-stage instructions that touch HI/LO.
- Supports exception cancellation of an issuing operation.

---
 rtl/md_sched_pkg.sv | 27 ++
 rtl/md_arith.sv | 45 ++++
 rtl/md_sched.sv | 101 ++++++++++
 tb/tb_md_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - op codes, FSM states and op-class helpers for the multiply/divide scheduler
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag
module md_arith
    import md_sched_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        signed_div;
    logic        neg_q;
    logic        neg_r;

    always_comb begin
        prod_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u      = {32'd0, a} * {32'd0, b};
        signed_div  = (op == MD_DIV);
        neg_q       = signed_div & (a[31] ^ b[31]);
        neg_r       = signed_div & a[31];
        // Magnitudes are unsigned, so 0x80000000 maps to itself and the
        // 0x80000000 / -1 case falls out as quotient 0x80000000, remainder 0.
        mag_a       = (signed_div && a[31]) ? -a : a;
        mag_b       = (signed_div && b[31]) ? -b : b;
        div_by_zero = is_div(op) && (b == 32'd0);
        divisor     = (b == 32'd0) ? 32'd1 : mag_b;
        quo_u       = mag_a / divisor;
        rem_u       = mag_a % divisor;
        case (op)
            MD_MULT:         result = prod_s;
            MD_MULTU:        result = prod_u;
            MD_DIV, MD_DIVU: result = {(neg_r ? -rem_u : rem_u), (neg_q ? -quo_u : quo_u)};
            default:         result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle MDU scheduler with HI/LO registers and hazard stall request
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_L = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_L  = CW'(DIV_CYCLES);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, b_q, hi_q, lo_q;
    logic [2:0]    op_q;
    logic          accept;
    logic          load;
    logic          commit;
    logic [63:0]   result;
    logic          div_by_zero;

    md_arith u_arith (
        .a           (a_q),
        .b           (b_q),
        .op          (op_q),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    assign accept = start & ~cancel & (state_q == S_IDLE);
    assign busy   = (state_q == S_BUSY);
    assign stall  = d_md_use & (busy | (start & ~cancel & is_muldiv(op)));
    assign hi     = hi_q;
    assign lo     = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_muldiv(op)) begin
                    load    = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = is_div(op) ? DIV_L : MULT_L;
                end
            end
            S_BUSY: begin
                // Completion frees the unit at the same edge so a follow-on op has no gap.
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
            if (accept && op == MD_MTHI) hi_q <= a;
            if (accept && op == MD_MTLO) lo_q <= a;
            if (commit && !div_by_zero) {hi_q, lo_q} <= result;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed and randomized self-checking bench for md_sched against a behavioural model
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        d_md_use = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_dbz;
    int          m_left;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .cancel   (cancel),
        .a        (a),
        .b        (b),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {hi,lo} straight from the arithmetic definitions using 64-bit integers.
    function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MD_MULT:  return sx * sy;
            MD_MULTU: return ux * uy;
            MD_DIV: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU:  return {32'(ux % uy), 32'(ux / uy)};
            default:  return 64'd0;
        endcase
    endfunction

    // Entered just after a rising edge: drive, check mid-cycle, clock, advance model.
    task automatic step(input logic s, input logic [2:0] o, input logic c,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic d, input logic r);
        logic exp_stall;
        start = s; op = o; cancel = c; a = aa; b = bb; d_md_use = d; reset = r;
        @(negedge clk);
        exp_stall = d && ((m_left > 0) || (s && !c && (o inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})));
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
        @(posedge clk);
        if (r) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            if (m_left == 1 && !m_dbz) {m_hi, m_lo} = m_res;
            m_left--;
        end else if (s && !c) begin
            case (o)
                MD_MTHI: m_hi = aa;
                MD_MTLO: m_lo = aa;
                MD_MULT, MD_MULTU: begin
                    m_left = MC; m_dbz = 1'b0; m_res = ref_calc(o, aa, bb);
                end
                MD_DIV, MD_DIVU: begin
                    m_left = DC; m_dbz = (bb == 32'd0);
                    m_res = m_dbz ? 64'd0 : ref_calc(o, aa, bb);
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) step(1'b0, MD_NONE, 1'b0, $urandom, $urandom, d, 1'b0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        step(1'b1, o, 1'b0, aa, bb, 1'b0, 1'b0);
    endtask

    initial begin
        m_hi = '0; m_lo = '0; m_left = 0; m_res = '0; m_dbz = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // Signed multiply with D-stage user: stall in issue and busy cycles, ignored restart in cycle 5
        step(1'b1, MD_MULT, 1'b0, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b1, MD_MULT, 1'b0, 32'd3, 32'd3, 1'b1, 1'b0);
        chk("mult_busy_c6", 64'(busy), 64'd0);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFFE);
        start = 1'b0; d_md_use = 1'b1;
        #1;
        chk("stall_c6", 64'(stall), 64'd0);
        #1;
        step(1'b1, MD_MULT, 1'b0, 32'd3, 32'd5, 1'b1, 1'b0);
        idle(MC, 1'b1);
        chk("b2b_lo", 64'(lo), 64'd15);
        chk("b2b_hi", 64'(hi), 64'd0);

        issue(MD_MULTU, 32'hFFFFFFFF, 32'h2);
        idle(MC, 1'b0);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        idle(DC, 1'b0);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);

        issue(MD_DIVU, 32'd7, 32'd2);
        idle(DC, 1'b0);
        chk("divu_lo", 64'(lo), 64'd3);
        chk("divu_hi", 64'(hi), 64'd1);

        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        idle(DC, 1'b0);
        chk("ovf_lo", 64'(lo), 64'h80000000);
        chk("ovf_hi", 64'(hi), 64'd0);

        // Divide by zero after MTHI
        step(1'b0, MD_NONE, 1'b0, '0, '0, 1'b0, 1'b1);
        issue(MD_MTHI, 32'h12345678, 32'd0);
        chk("mthi", 64'(hi), 64'h12345678);
        chk("mthi_busy", 64'(busy), 64'd0);
        issue(MD_DIVU, 32'd5, 32'd0);
        idle(DC - 1, 1'b0);
        chk("dbz_busy_last", 64'(busy), 64'd1);
        idle(1, 1'b0);
        chk("dbz_busy_end", 64'(busy), 64'd0);
        chk("dbz_hi", 64'(hi), 64'h12345678);
        chk("dbz_lo", 64'(lo), 64'd0);

        // Cancel at issue suppresses; cancel during busy does not
        step(1'b1, MD_MULT, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_lo", 64'(lo), 64'd0);
        issue(MD_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < DC; i++) step(1'b0, MD_NONE, 1'b1, '0, '0, 1'b0, 1'b0);
        chk("cancel_inflight_lo", 64'(lo), 64'd14);
        chk("cancel_inflight_hi", 64'(hi), 64'd2);

        // Reset in cycle 3 of a DIV, then no late commit
        issue(MD_DIVU, 32'd50, 32'd3);
        idle(2, 1'b0);
        step(1'b0, MD_NONE, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        idle(DC + 2, 1'b0);
        chk("no_late_lo", 64'(lo), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                 $urandom, rb, 1'($urandom), $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
